// File: rtl/bus_copy_pkg.sv
// Shared types and constants for the bus copy engine.
package bus_copy_pkg;
  typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, WRITE, DONE} state_e;
  localparam int unsigned WordBytes = 4;
endpackage

// File: rtl/bus_copy_engine.sv
// Bus leader that copies count words from src to dst one word at a time.
// Optional read-wait timeout enabled by defining BUS_COPY_TIMEOUT_EN.
module bus_copy_engine
  import bus_copy_pkg::*;
#(
  parameter int unsigned CountWidth    = 16,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [CountWidth-1:0] count,
  input  logic [3:0]            byte_enable,
  input  logic                  dst_incr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           bus_addr,
  output logic                  bus_read_req,
  output logic                  bus_write_req,
  output logic [3:0]            bus_byte_enable,
  output logic [31:0]           bus_write_data,
  input  logic [31:0]           bus_read_data,
  input  logic                  bus_read_data_valid
);

  state_e                state_q, state_d;
  logic [31:0]           src_q, src_d;
  logic [31:0]           dst_q, dst_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            be_q, be_d;
  logic                  incr_q, incr_d;

`ifdef BUS_COPY_TIMEOUT_EN
  localparam int unsigned WaitW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TimeoutCycles - 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      be_q    <= be_d;
      incr_q  <= incr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    be_d            = be_q;
    incr_d          = incr_q;
`ifdef BUS_COPY_TIMEOUT_EN
    wait_d          = wait_q;
    err_d           = err_q;
`endif
    bus_addr        = '0;
    bus_read_req    = 1'b0;
    bus_write_req   = 1'b0;
    bus_byte_enable = '0;
    bus_write_data  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          cnt_d  = count;
          be_d   = byte_enable;
          incr_d = dst_incr;
`ifdef BUS_COPY_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          state_d = (count == '0) ? DONE : READ_REQ;
        end
      end
      READ_REQ: begin
        bus_addr     = src_q;
        bus_read_req = 1'b1;
`ifdef BUS_COPY_TIMEOUT_EN
        wait_d       = '0;
`endif
        state_d      = READ_WAIT;
      end
      READ_WAIT: begin
        // A response on the final wait cycle still beats the timeout.
        if (bus_read_data_valid) begin
          data_d  = bus_read_data;
          state_d = WRITE;
        end
`ifdef BUS_COPY_TIMEOUT_EN
        else if (wait_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      WRITE: begin
        bus_addr        = dst_q;
        bus_write_req   = 1'b1;
        bus_byte_enable = be_q;
        bus_write_data  = data_q;
        src_d           = src_q + 32'(WordBytes);
        if (incr_q) dst_d = dst_q + 32'(WordBytes);
        cnt_d           = cnt_q - 1'b1;
        state_d         = (cnt_q == CountWidth'(1)) ? DONE : READ_REQ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
